// File: rtl/instruction_fetch_axi.sv
// Instruction fetch: AXI-Lite read master feeding decode through a first-word-fall-through prefetch FIFO.
// Redirects flush the FIFO and discard the responses of every request already issued.
module instruction_fetch_axi #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Enable,
  input  logic        i_Redirect_Valid,
  input  logic [31:0] i_Redirect_Pc,
  output logic        o_Instr_Valid,
  output logic [31:0] o_Instr,
  output logic [31:0] o_Instr_Pc,
  output logic        o_Instr_Fault,
  input  logic        i_Instr_Ready,
  output logic [31:0] m_axil_araddr,
  output logic        m_axil_arvalid,
  input  logic        m_axil_arready,
  input  logic [31:0] m_axil_rdata,
  input  logic [1:0]  m_axil_rresp,
  input  logic        m_axil_rvalid,
  output logic        m_axil_rready
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW:0] DEPTH = CW1'(FIFO_DEPTH);

  logic [31:0]   fetch_pc, fetch_pc_nxt, resp_pc, resp_pc_nxt, araddr_nxt, target;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, discard_nxt, count, count_nxt;
  logic          arvalid_nxt, ar_stale, ar_stale_nxt, valid_nxt;
  logic          ar_hs, r_hs, pop, push, pending;
  logic [CW:0]   credit;

  logic [31:0] q_pc      [FIFO_DEPTH];
  logic [31:0] q_data    [FIFO_DEPTH];
  logic        q_fault   [FIFO_DEPTH];
  logic [31:0] q_pc_nxt  [FIFO_DEPTH];
  logic [31:0] q_data_nxt[FIFO_DEPTH];
  logic        q_fault_nxt[FIFO_DEPTH];

  // Next-state for request tracking, response routing, FIFO and AR issue
  always_comb begin
    ar_hs   = m_axil_arvalid && m_axil_arready;
    r_hs    = m_axil_rvalid && m_axil_rready;
    pop     = o_Instr_Valid && i_Instr_Ready;
    pending = m_axil_arvalid && !m_axil_arready;
    target  = i_Redirect_Pc & ~32'h3;

    fetch_pc_nxt    = fetch_pc;
    resp_pc_nxt     = resp_pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    count_nxt       = count;
    arvalid_nxt     = m_axil_arvalid;
    araddr_nxt      = m_axil_araddr;
    ar_stale_nxt    = ar_stale;
    q_pc_nxt        = q_pc;
    q_data_nxt      = q_data;
    q_fault_nxt     = q_fault;
    push            = 1'b0;
    credit          = '0;

    // A request issued before a redirect must not advance the new fetch PC
    if (ar_hs) begin
      outstanding_nxt = outstanding + CW'(1);
      arvalid_nxt     = 1'b0;
      ar_stale_nxt    = 1'b0;
      if (!ar_stale) fetch_pc_nxt = fetch_pc + 32'd4;
    end
    if (r_hs) outstanding_nxt = outstanding_nxt - CW'(1);

    if (i_Redirect_Valid) begin
      fetch_pc_nxt = target;
      resp_pc_nxt  = target;
      count_nxt    = '0;
      discard_nxt  = outstanding_nxt + CW'(pending);
      ar_stale_nxt = pending;
    end else begin
      if (r_hs) begin
        if (discard != '0) begin
          discard_nxt = discard - CW'(1);
        end else begin
          push        = 1'b1;
          resp_pc_nxt = resp_pc + 32'd4;
        end
      end
      if (pop) begin
        for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
          q_pc_nxt[i]    = q_pc[i+1];
          q_data_nxt[i]  = q_data[i+1];
          q_fault_nxt[i] = q_fault[i+1];
        end
        count_nxt = count - CW'(1);
      end
      if (push) begin
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
          if (CW'(i) == count_nxt) begin
            q_pc_nxt[i]    = resp_pc;
            q_data_nxt[i]  = m_axil_rdata;
            q_fault_nxt[i] = (m_axil_rresp != 2'b00);
          end
        end
        count_nxt = count_nxt + CW'(1);
      end
      // Every issued request, including ones whose data will be dropped, holds a FIFO slot
      credit = {1'b0, outstanding_nxt} + {1'b0, count_nxt} + CW1'(1);
      if (i_Enable && !pending && (credit <= DEPTH)) begin
        arvalid_nxt = 1'b1;
        araddr_nxt  = fetch_pc_nxt;
      end
    end
    valid_nxt = (count_nxt != '0);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      discard        <= '0;
      count          <= '0;
      ar_stale       <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_araddr  <= RESET_PC;
      m_axil_rready  <= 1'b0;
      o_Instr_Valid  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        q_pc[i]    <= RESET_PC;
        q_data[i]  <= '0;
        q_fault[i] <= 1'b0;
      end
    end else begin
      fetch_pc       <= fetch_pc_nxt;
      resp_pc        <= resp_pc_nxt;
      outstanding    <= outstanding_nxt;
      discard        <= discard_nxt;
      count          <= count_nxt;
      ar_stale       <= ar_stale_nxt;
      m_axil_arvalid <= arvalid_nxt;
      m_axil_araddr  <= araddr_nxt;
      m_axil_rready  <= 1'b1;
      o_Instr_Valid  <= valid_nxt;
      q_pc           <= q_pc_nxt;
      q_data         <= q_data_nxt;
      q_fault        <= q_fault_nxt;
    end
  end

  assign o_Instr       = q_data[0];
  assign o_Instr_Pc    = q_pc[0];
  assign o_Instr_Fault = q_fault[0];

  // The credit scheme must make a push into a full FIFO impossible
  assert property (@(posedge i_Clock) disable iff (!i_Reset_n)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_axi.sv
// Bench for instruction_fetch_axi: AXI-Lite RAM responder, expected-instruction-stream scoreboard,
// directed scenarios followed by randomized traffic with redirects.
module tb_instruction_fetch_axi;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_fault, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [31:0] araddr, rdata = '0;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [1:0]  rresp = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        fault;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] next_pc = RESET_PC;
  logic [31:0] ar_log[$];
  logic [31:0] rq[$];
  int          n_checks = 0, n_pass = 0, n_deliv = 0;
  int          ar_mode = 0, r_mode = 0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  bit          rand_faults = 1'b0;

  instruction_fetch_axi #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Enable(enable),
    .i_Redirect_Valid(redirect), .i_Redirect_Pc(redirect_pc),
    .o_Instr_Valid(instr_valid), .o_Instr(instr), .o_Instr_Pc(instr_pc),
    .o_Instr_Fault(instr_fault), .i_Instr_Ready(instr_ready),
    .m_axil_araddr(araddr), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  // RAM contents: 0x13, 0x93, 0x113 at 0x0, 0x4, 0x8 and so on
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[26:0], 5'b0} | 32'h13;
  endfunction

  function automatic logic fault_at(input logic [31:0] a);
    return (a == fault_addr) || (rand_faults && (a[5:2] == 4'hB));
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    next_pc = pc & ~32'h3;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; enable = 1'b1; instr_ready = 1'b0;
    cycles(2);
    check("reset_ctl", 96'({instr_valid, arvalid, rready, instr_fault}), 96'(0));
    check("reset_addr", 96'({araddr, instr_pc, instr}), 96'({RESET_PC, RESET_PC, 32'h0}));
    ar_log.delete();
    restart_stream(RESET_PC);
    rst_n = 1'b1;
  endtask

  task automatic wait_ar(input int n, input int budget, input string name);
    int k = 0;
    while (ar_log.size() < n && k < budget) begin cycles(1); k++; end
    check(name, 96'(ar_log.size() >= n), 96'(1));
  endtask

  task automatic wait_deliv(input int from, input int budget, input string name);
    int k = 0;
    while (n_deliv <= from && k < budget) begin cycles(1); k++; end
    check(name, 96'(n_deliv > from), 96'(1));
  endtask

  // AXI-Lite RAM: logs AR handshakes, returns data in order with mode-dependent latency
  initial begin : slave
    logic        ar_fire, r_fire;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      ar_fire = arvalid && arready && rst_n;
      r_fire  = rvalid && rready && rst_n;
      a       = araddr;
      if (ar_fire) ar_log.push_back(a);
      @(posedge clk);
      #2;
      if (!rst_n) begin
        rq.delete(); rvalid = 1'b0; arready = 1'b0;
        continue;
      end
      if (r_fire) rvalid = 1'b0;
      if (ar_fire) rq.push_back(a);
      case (ar_mode)
        0:       arready = 1'b1;
        1:       arready = 1'($urandom_range(0, 1));
        default: arready = 1'b0;
      endcase
      if (!rvalid && rq.size() > 0 && (r_mode == 0 || (r_mode == 1 && $urandom_range(0, 2) != 0))) begin
        a      = rq.pop_front();
        rvalid = 1'b1;
        rdata  = word_at(a);
        rresp  = fault_at(a) ? 2'b10 : 2'b00;
      end
    end
  end

  // Scoreboard monitor: expected stream is sequential PCs from the last restart point
  initial begin : monitor
    item_t       e, it;
    logic [64:0] got;
    logic        prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      while (exp_q.size() < 8) begin
        it.pc = next_pc; it.word = word_at(next_pc); it.fault = fault_at(next_pc);
        exp_q.push_back(it);
        next_pc = next_pc + 32'd4;
      end
      if (!rst_n) begin prev_stall = 1'b0; continue; end
      if (prev_stall) check("ar_hold", 96'({arvalid, araddr}), 96'({1'b1, prev_addr}));
      prev_stall = arvalid && !arready;
      prev_addr  = araddr;
      if (instr_valid && instr_ready) begin
        got = {instr_pc, instr, instr_fault};
        e   = exp_q.pop_front();
        check("instr", 96'(got), 96'(e));
        n_deliv++;
      end
    end
  end

  initial begin : stim
    int          d0;
    int          k;
    logic [31:0] tgt;
    tgt = '0;

    // Straight-line fetch with a faulting word at 0x4
    fault_addr = 32'h4; ar_mode = 0; r_mode = 0;
    do_reset();
    instr_ready = 1'b1;
    d0 = n_deliv;
    cycles(1);
    check("rready_up", 96'(rready), 96'(1));
    check("ar_first", 96'({arvalid, araddr}), 96'({1'b1, 32'h0}));
    cycles(1);
    check("ar_b2b", 96'({arvalid, araddr}), 96'({1'b1, 32'h4}));
    wait_ar(3, 20, "t1_ar_count");
    check("t1_ar_addrs", 96'({ar_log[0], ar_log[1], ar_log[2]}), 96'({32'h0, 32'h4, 32'h8}));
    cycles(10);
    check("t1_deliv", 96'(n_deliv - d0 >= 3), 96'(1));

    // Back-pressure: FIFO fills with two words, then one pop frees credit for 0x8
    fault_addr = 32'hFFFF_FFFF;
    do_reset();
    cycles(12);
    check("bp_ar_count", 96'(ar_log.size()), 96'(2));
    check("bp_ar_addrs", 96'({ar_log[0], ar_log[1]}), 96'({32'h0, 32'h4}));
    check("bp_full", 96'({arvalid, instr_valid}), 96'({1'b0, 1'b1}));
    instr_ready = 1'b1;
    cycles(1);
    instr_ready = 1'b0;
    cycles(5);
    check("bp_release", 96'({32'(ar_log.size()), ar_log[2]}), 96'({32'd3, 32'h8}));
    instr_ready = 1'b1;
    cycles(20);

    // Redirect with two reads outstanding
    do_reset();
    r_mode = 2; instr_ready = 1'b1;
    cycles(6);
    check("rd_inflight", 96'({32'(ar_log.size()), 31'd0, instr_valid}), 96'({32'd2, 32'd0}));
    redirect = 1'b1; redirect_pc = 32'h103;
    cycles(1);
    redirect = 1'b0;
    restart_stream(32'h100);
    r_mode = 0;
    d0 = n_deliv;
    wait_deliv(d0, 30, "rd_deliv");
    check("rd_ar_target", 96'(ar_log[2]), 96'(32'h100));
    cycles(10);

    // Redirect while an AR is stalled on arready
    do_reset();
    instr_ready = 1'b1;
    wait_ar(2, 20, "st_ar_count");
    ar_mode = 2;
    k = 0;
    while (!(arvalid && araddr == 32'h8) && k < 20) begin cycles(1); k++; end
    check("st_stalled", 96'({arvalid, araddr}), 96'({1'b1, 32'h8}));
    redirect = 1'b1; redirect_pc = 32'h200;
    cycles(1);
    redirect = 1'b0;
    restart_stream(32'h200);
    cycles(4);
    check("st_hold", 96'({arvalid, araddr}), 96'({1'b1, 32'h8}));
    ar_mode = 0;
    wait_ar(4, 30, "st_ar_after");
    check("st_ar_addrs", 96'({ar_log[2], ar_log[3]}), 96'({32'h8, 32'h200}));
    d0 = n_deliv;
    wait_deliv(d0, 30, "st_deliv");

    // Asynchronous reset mid-burst, away from any clock edge
    do_reset();
    instr_ready = 1'b1;
    cycles(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 96'({arvalid, instr_valid}), 96'(0));
    do_reset();
    instr_ready = 1'b1;
    wait_ar(1, 10, "async_ar");
    check("async_restart", 96'(ar_log[0]), 96'(RESET_PC));
    d0 = n_deliv;
    wait_deliv(d0, 30, "async_deliv");

    // Randomized traffic, back-pressure, enable gaps and redirects (some back-to-back, some wrapping)
    rand_faults = 1'b1; ar_mode = 1; r_mode = 1;
    do_reset();
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 9) != 0);
      if (redirect) begin
        redirect = 1'b0;
        restart_stream(tgt);
        if ($urandom_range(0, 3) == 0) redirect = 1'b1;
      end else if ($urandom_range(0, 29) == 0) begin
        redirect = 1'b1;
      end
      if (redirect) begin
        tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : 32'($urandom_range(0, 32'hFFF));
        redirect_pc = tgt;
      end
      cycles(1);
    end
    if (redirect) begin
      redirect = 1'b0;
      restart_stream(tgt);
    end
    enable = 1'b1; instr_ready = 1'b1;
    cycles(50);
    check("rand_progress", 96'(n_deliv - d0 > 200), 96'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
